// File: rtl/i2c_slave_regs_if.sv
// i2c_slave_regs_if -- register-bank export of the I2C target.
//   REGS      : flat register bank, reg[i] = REGS[8*i+7:8*i]
//   WR_STROBE : one-clock pulse per committed data-byte write
//   WR_PTR    : register index written, valid with WR_STROBE
//   BUSY      : target addressed and transaction in progress
// Modport slave is the I2C target side (drives the bank).
// Modport master is the downstream consumer side (reads the bank).
interface i2c_slave_regs_if #(
  parameter int PTR_W = 2
);
  logic [8*(2**PTR_W)-1:0] REGS;
  logic                    WR_STROBE;
  logic [PTR_W-1:0]        WR_PTR;
  logic                    BUSY;

  modport slave  (output REGS, WR_STROBE, WR_PTR, BUSY);
  modport master (input  REGS, WR_STROBE, WR_PTR, BUSY);
endinterface

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs -- I2C target with a small register bank.
// The first byte after START is matched against ADDRESS. On a write, the
// second byte sets the register pointer and further bytes are stored at
// the pointer, which auto-increments. On a read, bytes are returned from
// the pointer, which advances on each master ACK.
// Ports:
//   CLK  : system clock, >= 16x SCL
//   RST  : asynchronous active-low reset
//   SCL  : bus clock (input only)
//   SDA  : bus data, driven only to 0 or released
//   bank : register-bank export (REGS, WR_STROBE, WR_PTR, BUSY)
module i2c_slave_regs #(
  parameter logic [6:0] ADDRESS = 7'h26,
  parameter int         PTR_W   = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            SCL,
  inout  wire             SDA,
  i2c_slave_regs_if.slave bank
);
  localparam int NREG = 2**PTR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_PTR, S_WDATA, S_RDATA, S_IGNORE, S_WAIT_STOP
  } state_t;

  state_t                 state;
  // [0],[1] synchronizer, [2] previous synced value for edge detection
  logic [2:0]             scl_pipe, sda_pipe;
  // bit_cnt counts SCL rises in a byte; 8 = ACK slot pending, 9 = ACK sampled
  logic [3:0]             bit_cnt;
  logic [6:0]             shreg;
  logic [7:0]             tx;
  logic [PTR_W-1:0]       ptr;
  logic                   rw;
  logic                   ack_en;
  logic                   sda_oe;
  logic [NREG-1:0][7:0]   regs_q;
  logic                   wr_strobe;
  logic [PTR_W-1:0]       wr_ptr;
  logic                   busy;

  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_det, stop_det;
  logic                   bit_in;
  logic [7:0]             byte_in;
  logic [PTR_W-1:0]       ptr_nxt;

  assign SDA = sda_oe ? 1'b0 : 1'bz;

  assign bank.REGS      = regs_q;
  assign bank.WR_STROBE = wr_strobe;
  assign bank.WR_PTR    = wr_ptr;
  assign bank.BUSY      = busy;

  assign scl_rise  =  scl_pipe[1] & ~scl_pipe[2];
  assign scl_fall  = ~scl_pipe[1] &  scl_pipe[2];
  assign sda_rise  =  sda_pipe[1] & ~sda_pipe[2];
  assign sda_fall  = ~sda_pipe[1] &  sda_pipe[2];
  // Our own ACK/data drive must never be mistaken for a bus condition.
  assign start_det = sda_fall & scl_pipe[1] & ~sda_oe;
  assign stop_det  = sda_rise & scl_pipe[1] & ~sda_oe;

  assign bit_in  = sda_pipe[1];
  assign byte_in = {shreg, bit_in};
  assign ptr_nxt = ptr + PTR_W'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scl_pipe  <= '1;
      sda_pipe  <= '1;
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_en    <= 1'b0;
      sda_oe    <= 1'b0;
      regs_q    <= '0;
      wr_strobe <= 1'b0;
      wr_ptr    <= '0;
      busy      <= 1'b0;
    end else begin
      scl_pipe  <= {scl_pipe[1:0], SCL};
      sda_pipe  <= {sda_pipe[1:0], SDA};
      wr_strobe <= 1'b0;

      if (start_det) begin
        // Covers repeated START; any partial byte is dropped.
        state   <= S_ADDR;
        bit_cnt <= '0;
        ack_en  <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        ack_en  <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WDATA, S_RDATA: begin
            if (scl_rise) begin
              if (bit_cnt < 4'd8) begin
                shreg   <= byte_in[6:0];
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                  // Full byte present at the 8th rise.
                  case (state)
                    S_ADDR: begin
                      if (byte_in[7:1] == ADDRESS) begin
                        ack_en <= 1'b1;
                        busy   <= 1'b1;
                        rw     <= byte_in[0];
                      end else begin
                        state  <= S_IGNORE;
                        busy   <= 1'b0;
                      end
                    end
                    S_PTR: begin
                      ptr    <= byte_in[PTR_W-1:0];
                      ack_en <= 1'b1;
                    end
                    S_WDATA: begin
                      regs_q[ptr] <= byte_in;
                      wr_strobe   <= 1'b1;
                      wr_ptr      <= ptr;
                      ptr         <= ptr_nxt;
                      ack_en      <= 1'b1;
                    end
                    default: ;
                  endcase
                end
              end else if (bit_cnt == 4'd8) begin
                // 9th rise: ACK slot sampled, decide where the next byte goes.
                bit_cnt <= 4'd9;
                case (state)
                  S_ADDR: begin
                    if (rw) begin
                      state <= S_RDATA;
                      tx    <= regs_q[ptr];
                    end else begin
                      state <= S_PTR;
                    end
                  end
                  S_PTR: state <= S_WDATA;
                  S_RDATA: begin
                    if (!bit_in) begin
                      ptr <= ptr_nxt;
                      tx  <= regs_q[ptr_nxt];
                    end else begin
                      state <= S_WAIT_STOP;
                    end
                  end
                  default: ;
                endcase
              end
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                // ACK our own byte; in RDATA ack_en is 0 so SDA is released
                // for the master's ACK/NACK.
                sda_oe <= ack_en;
              end else if (bit_cnt == 4'd9) begin
                bit_cnt <= '0;
                ack_en  <= 1'b0;
                if (state == S_RDATA) begin
                  sda_oe <= ~tx[7];
                  tx     <= {tx[6:0], 1'b0};
                end else begin
                  sda_oe <= 1'b0;
                end
              end else if (state == S_RDATA && bit_cnt != 4'd0) begin
                sda_oe <= ~tx[7];
                tx     <= {tx[6:0], 1'b0};
              end
            end
          end
          default: begin
            // IDLE / IGNORE / WAIT_STOP: bus released, wait for START/STOP.
            bit_cnt <= '0;
            ack_en  <= 1'b0;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs -- directed self-checking bench for i2c_slave_regs.
// Acts as the I2C master on an open-drain SDA with pull-up.
module tb_i2c_slave_regs;
  localparam int Q = 10;  // quarter-ish SCL phase in CLK cycles

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl   = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_regs_if #(.PTR_W(2)) bank ();

  i2c_slave_regs #(.ADDRESS(7'h26), .PTR_W(2)) dut (
    .CLK  (clk),
    .RST  (rst_n),
    .SCL  (scl),
    .SDA  (sda),
    .bank (bank)
  );

  // Bus monitors, sampled on the opposite clock edge.
  int         strobe_cnt  = 0;
  int         dut_low_cnt = 0;
  int         busy_cnt    = 0;
  logic [1:0] wp_log [0:63];

  always @(negedge clk) begin
    if (bank.WR_STROBE === 1'b1) begin
      wp_log[strobe_cnt[5:0]] <= bank.WR_PTR;
      strobe_cnt <= strobe_cnt + 1;
    end
    if (sda === 1'b0 && !m_low) dut_low_cnt <= dut_low_cnt + 1;
    if (bank.BUSY === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    m_low = 1'b1; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    m_low = 1'b0; wait_clk(Q);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    m_low = ~b;   wait_clk(Q);
    scl   = 1'b1; wait_clk(Q/2);
    s     = sda;  wait_clk(Q/2);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(nack, s);
  endtask

  initial begin
    logic       a;
    logic       s;
    logic [7:0] d;
    int         s0, l0, b0;

    // Reset state
    wait_clk(5);
    check("rst_regs",   64'(bank.REGS), 64'h0);
    check("rst_busy",   64'(bank.BUSY), 64'h0);
    check("rst_strobe", 64'(bank.WR_STROBE), 64'h0);
    check("rst_sda",    64'(sda), 64'h1);
    rst_n = 1'b1;
    wait_clk(5);

    // Write two bytes from pointer 1
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h4C, a); check("w1_ack_addr", 64'(a), 64'h0);
    write_byte(8'h01, a); check("w1_ack_ptr",  64'(a), 64'h0);
    write_byte(8'hA5, a); check("w1_ack_d0",   64'(a), 64'h0);
    write_byte(8'h3C, a); check("w1_ack_d1",   64'(a), 64'h0);
    check("w1_busy", 64'(bank.BUSY), 64'h1);
    i2c_stop();
    check("w1_busy_after_stop", 64'(bank.BUSY), 64'h0);
    check("w1_regs",      64'(bank.REGS), 64'h003CA500);
    check("w1_strobes",   64'(strobe_cnt - s0), 64'd2);
    check("w1_wp0",       64'(wp_log[s0]), 64'd1);
    check("w1_wp1",       64'(wp_log[s0+1]), 64'd2);

    // Preload reg3/reg0 through write-pointer wrap
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h4C, a);
    write_byte(8'h03, a);
    write_byte(8'h5A, a); check("pl_ack_d0", 64'(a), 64'h0);
    write_byte(8'h11, a); check("pl_ack_d1", 64'(a), 64'h0);
    i2c_stop();
    check("pl_regs", 64'(bank.REGS), 64'h5A3CA511);
    check("pl_wp0",  64'(wp_log[s0]), 64'd3);
    check("pl_wp1",  64'(wp_log[s0+1]), 64'd0);

    // Read with repeated START and read-pointer wrap
    i2c_start();
    write_byte(8'h4C, a); check("rd_ack_addw", 64'(a), 64'h0);
    write_byte(8'h03, a); check("rd_ack_ptr",  64'(a), 64'h0);
    i2c_start();
    write_byte(8'h4D, a); check("rd_ack_addr", 64'(a), 64'h0);
    read_byte(1'b0, d);   check("rd_byte0", 64'(d), 64'h5A);
    read_byte(1'b1, d);   check("rd_byte1", 64'(d), 64'h11);
    check("rd_release_after_nack", 64'(sda), 64'h1);
    i2c_stop();
    i2c_start();
    write_byte(8'h4D, a); check("rd2_ack_addr", 64'(a), 64'h0);
    read_byte(1'b1, d);   check("rd2_ptr_wrapped", 64'(d), 64'h11);
    i2c_stop();

    // Address mismatch
    s0 = strobe_cnt; l0 = dut_low_cnt; b0 = busy_cnt;
    i2c_start();
    write_byte(8'h4E, a); check("mm_nack_addr", 64'(a), 64'h1);
    write_byte(8'h00, a); check("mm_nack_d0",   64'(a), 64'h1);
    write_byte(8'hFF, a); check("mm_nack_d1",   64'(a), 64'h1);
    i2c_stop();
    check("mm_sda_never_low", 64'(dut_low_cnt - l0), 64'd0);
    check("mm_no_strobe",     64'(strobe_cnt - s0), 64'd0);
    check("mm_busy_never",    64'(busy_cnt - b0), 64'd0);
    check("mm_regs",          64'(bank.REGS), 64'h5A3CA511);

    // Aborted byte, then a full write to pointer 0
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h4C, a);
    write_byte(8'h00, a);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, s);
    i2c_stop();
    check("ab_regs",      64'(bank.REGS), 64'h5A3CA511);
    check("ab_no_strobe", 64'(strobe_cnt - s0), 64'd0);
    check("ab_busy",      64'(bank.BUSY), 64'h0);
    i2c_start();
    write_byte(8'h4C, a);
    write_byte(8'h00, a);
    write_byte(8'h0F, a); check("ab_ack_retry", 64'(a), 64'h0);
    i2c_stop();
    check("ab_regs_retry", 64'(bank.REGS), 64'h5A3CA50F);
    check("ab_wp_retry",   64'(wp_log[s0]), 64'd0);

    // Pointer byte upper bits ignored
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h4C, a);
    write_byte(8'hF6, a); check("pu_ack_ptr", 64'(a), 64'h0);
    write_byte(8'h77, a);
    i2c_stop();
    check("pu_regs", 64'(bank.REGS), 64'h5A77A50F);
    check("pu_wp",   64'(wp_log[s0]), 64'd2);

    // Reset while the block drives a 0 data bit (reg1 = 0xA5: bit7=1, bit6=0)
    i2c_start();
    write_byte(8'h4C, a);
    write_byte(8'h01, a);
    i2c_start();
    write_byte(8'h4D, a); check("rr_ack_addr", 64'(a), 64'h0);
    bit_cycle(1'b1, s);   check("rr_bit7", 64'(s), 64'h1);
    check("rr_driving_low", 64'(sda), 64'h0);
    rst_n = 1'b0;
    #1;
    check("rr_sda_released", 64'(sda), 64'h1);
    check("rr_regs_clear",   64'(bank.REGS), 64'h0);
    check("rr_busy_clear",   64'(bank.BUSY), 64'h0);
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    i2c_start();
    write_byte(8'h4C, a); check("rr_post_ack_addr", 64'(a), 64'h0);
    write_byte(8'h02, a);
    write_byte(8'h99, a); check("rr_post_ack_d0", 64'(a), 64'h0);
    i2c_stop();
    check("rr_post_regs", 64'(bank.REGS), 64'h00990000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
